key_event_sched: RTL and testbench

- Schedules all key events into the single key_strobe/key_pressed/key_extended/key_code stream consumed by the Spectrum keyboard matrix.
- Arbitrates between two requesters: live PS/2 events from the host IO and a macro/auto-type source using a valid/ready handshake.
- Live events are buffered in a small FIFO. Output events are paced so the ROM keyboard scan sees every press and release.
- Provides an Escape abort pulse for the macro player.

---
 rtl/key_event_sched.sv | 134 +++++++++++++
 tb/tb_key_event_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_sched.sv
`default_nettype none
// =============================================================================
//  Module      : key_event_sched
//  Description : Merges live PS/2 key events (via a small FIFO) and macro
//                key events into one paced key stream for the keyboard matrix.
//  Revision    : 1.0 - initial release
// =============================================================================
module key_event_sched #(
    parameter int GAP_CYCLES = 7000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       live_strobe,
    input  logic       live_pressed,
    input  logic       live_extended,
    input  logic [7:0] live_code,
    input  logic       mac_valid,
    input  logic [9:0] mac_data,
    output logic       mac_ready,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       mac_abort,
    output logic       overflow,
    output logic       busy
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
    localparam logic [c_cw-1:0] c_gap_load = c_cw'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_aw:0]   r_wr_ptr;
    logic [c_aw:0]   r_rd_ptr;
    logic            r_key_strobe;
    logic            r_key_pressed;
    logic            r_key_extended;
    logic [7:0]      r_key_code;
    logic            r_mac_abort;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_mac_take;
    logic            w_issue;
    logic            w_esc_make;
    logic [9:0]      w_head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_head     = r_mem[r_rd_ptr[c_aw-1:0]];
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_push     = live_strobe && (!w_full || w_pop);
    assign mac_ready  = (r_state == S_IDLE) && w_empty;
    assign w_mac_take = mac_ready && mac_valid;
    assign w_issue    = w_pop || w_mac_take;
    assign w_esc_make = live_strobe && live_pressed && !live_extended &&
                        (live_code == 8'h76);

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {live_pressed, live_extended, live_code};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_key_strobe   <= 1'b0;
            r_key_pressed  <= 1'b0;
            r_key_extended <= 1'b0;
            r_key_code     <= '0;
            r_mac_abort    <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_key_strobe <= w_issue;
            r_mac_abort  <= w_esc_make;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_aw + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
            end
            if (live_strobe && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_issue) begin
                {r_key_pressed, r_key_extended, r_key_code} <= w_pop ? w_head : mac_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_issue && (GAP_CYCLES > 1)) begin
                        r_state <= S_GAP;
                        r_cnt   <= c_gap_load;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_cw'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign key_strobe   = r_key_strobe;
    assign key_pressed  = r_key_pressed;
    assign key_extended = r_key_extended;
    assign key_code     = r_key_code;
    assign mac_abort    = r_mac_abort;
    assign overflow     = r_overflow;
    assign busy         = (r_state == S_GAP) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_key_event_sched.sv
`default_nettype none
// =============================================================================
//  Module      : tb_key_event_sched
//  Description : Directed self-checking bench for key_event_sched
//                (GAP_CYCLES=4, FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_key_event_sched;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b0;
    logic       live_strobe = 1'b0;
    logic       live_pressed = 1'b0;
    logic       live_extended = 1'b0;
    logic [7:0] live_code = '0;
    logic       mac_valid = 1'b0;
    logic [9:0] mac_data = '0;
    logic       mac_ready;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       mac_abort;
    logic       overflow;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    key_event_sched #(
        .GAP_CYCLES (4),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .live_strobe   (live_strobe),
        .live_pressed  (live_pressed),
        .live_extended (live_extended),
        .live_code     (live_code),
        .mac_valid     (mac_valid),
        .mac_data      (mac_data),
        .mac_ready     (mac_ready),
        .key_strobe    (key_strobe),
        .key_pressed   (key_pressed),
        .key_extended  (key_extended),
        .key_code      (key_code),
        .mac_abort     (mac_abort),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        live_strobe = 1'b0;
        mac_valid   = 1'b0;
        reset       = 1'b1;
        step();
        reset       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] w3 [3];
        logic [7:0] e_code [3];
        logic       e_ext  [3];
        logic       e_pr   [3];
        int         idx;
        int         k;
        int         t;

        // reset state
        do_reset();
        check_eq("rst_strobe",   key_strobe, 0);
        check_eq("rst_code",     key_code, 0);
        check_eq("rst_pressed",  key_pressed, 0);
        check_eq("rst_abort",    mac_abort, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_busy",     busy, 0);
        check_eq("rst_ready",    mac_ready, 1);

        // single live event
        for (int c = 0; c <= 8; c++) begin
            check_eq("t1_strobe", key_strobe, (c == 2));
            check_eq("t1_busy",   busy, (c >= 1 && c <= 4));
            if (c == 2) begin
                check_eq("t1_code",     key_code, 8'h1C);
                check_eq("t1_pressed",  key_pressed, 1);
                check_eq("t1_extended", key_extended, 0);
            end
            live_strobe   = (c == 0);
            live_pressed  = 1'b1;
            live_extended = 1'b0;
            live_code     = 8'h1C;
            step();
        end
        live_strobe = 1'b0;

        // overflow
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            check_eq("t2_strobe", key_strobe, (c >= 2 && c <= 22 && ((c - 2) % 4) == 0));
            if (c >= 2 && c <= 22 && ((c - 2) % 4) == 0) begin
                check_eq("t2_code", key_code, (c - 2) / 4 + 1);
            end
            check_eq("t2_overflow", overflow, (c >= 7));
            if (c == 7)  check_eq("t2_busy_full", busy, 1);
            if (c >= 25) check_eq("t2_busy_done", busy, 0);
            live_strobe   = (c <= 6);
            live_pressed  = 1'b1;
            live_extended = 1'b0;
            live_code     = 8'(c + 1);
            step();
        end
        live_strobe = 1'b0;

        // macro stream
        do_reset();
        w3[0] = 10'h11C; w3[1] = 10'h01C; w3[2] = 10'h15A;
        e_code[0] = 8'h1C; e_code[1] = 8'h1C; e_code[2] = 8'h5A;
        e_ext[0]  = 1'b1;  e_ext[1]  = 1'b0;  e_ext[2]  = 1'b1;
        e_pr[0]   = 1'b0;  e_pr[1]   = 1'b0;  e_pr[2]   = 1'b0;
        idx = 0;
        for (int c = 0; c <= 12; c++) begin
            check_eq("t3_ready",  mac_ready, (c == 0 || c == 4 || c == 8 || c >= 12));
            check_eq("t3_strobe", key_strobe, (c == 1 || c == 5 || c == 9));
            if (c == 1 || c == 5 || c == 9) begin
                k = (c - 1) / 4;
                check_eq("t3_code",     key_code, e_code[k]);
                check_eq("t3_extended", key_extended, e_ext[k]);
                check_eq("t3_pressed",  key_pressed, e_pr[k]);
            end
            mac_valid = (idx < 3);
            mac_data  = (idx < 3) ? w3[idx] : 10'h000;
            if (mac_valid && mac_ready) idx++;
            step();
        end
        mac_valid = 1'b0;
        check_eq("t3_words_taken", idx, 3);

        // live preempts a waiting macro word
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            t = i - 2;
            check_eq("t4_ready",  mac_ready, (t == -2 || t == 6));
            check_eq("t4_strobe", key_strobe, (t == -1 || t == 3 || t == 7));
            if (t == 3) begin
                check_eq("t4_live_code",    key_code, 8'h29);
                check_eq("t4_live_pressed", key_pressed, 1);
            end
            if (t == 7) begin
                check_eq("t4_mac_code",    key_code, 8'h33);
                check_eq("t4_mac_pressed", key_pressed, 1);
                check_eq("t4_mac_ext",     key_extended, 0);
            end
            mac_valid     = (t == -2) || (t >= 0 && t <= 6);
            mac_data      = (t == -2) ? 10'h000 : 10'h233;
            live_strobe   = (t == 0);
            live_pressed  = 1'b1;
            live_extended = 1'b0;
            live_code     = 8'h29;
            step();
        end
        mac_valid   = 1'b0;
        live_strobe = 1'b0;

        // Escape abort qualification
        do_reset();
        e_pr[0] = 1'b1; e_pr[1] = 1'b0; e_pr[2] = 1'b1;
        e_ext[0] = 1'b0; e_ext[1] = 1'b0; e_ext[2] = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            check_eq("t5_abort",  mac_abort, (c == 1));
            check_eq("t5_strobe", key_strobe, (c == 2 || c == 6 || c == 10));
            if (c == 2 || c == 6 || c == 10) begin
                k = (c - 2) / 4;
                check_eq("t5_code",     key_code, 8'h76);
                check_eq("t5_pressed",  key_pressed, e_pr[k]);
                check_eq("t5_extended", key_extended, e_ext[k]);
            end
            live_strobe   = (c == 0 || c == 4 || c == 8);
            live_pressed  = (c != 4);
            live_extended = (c == 8);
            live_code     = 8'h76;
            step();
        end
        live_strobe = 1'b0;

        // reset mid-operation
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            live_strobe   = 1'b1;
            live_pressed  = 1'b1;
            live_extended = 1'b0;
            live_code     = 8'(c + 8'h40);
            step();
        end
        live_strobe = 1'b0;
        check_eq("t6_pre_overflow", overflow, 1);
        check_eq("t6_pre_busy",     busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_code", key_code, 0);
        for (int c = 0; c <= 6; c++) begin
            check_eq("t6_strobe",   key_strobe, 0);
            check_eq("t6_busy",     busy, 0);
            check_eq("t6_overflow", overflow, 0);
            check_eq("t6_ready",    mac_ready, 1);
            check_eq("t6_abort",    mac_abort, 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
